serial_alu_slice: RTL and testbench

//  Parametrised bit-serial ALU for the toy processor datapath. Each clock it runs one
//  bit through a logic/arithmetic extender and full-adder slice, LSB first, with a carry flip-flop.

---
 rtl/serial_alu_slice.sv | 148 ++++++++++++++
 tb/tb_serial_alu_slice.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_slice.sv
// serial_alu_slice
//   Bit-serial ALU. One bit per clock, LSB first, through an operand extender
//   and a full-adder slice. A carry flip-flop links the bits. Operands and the
//   op select are captured when a start is accepted. The result and flags are
//   held until the next accepted start.
//
//   Ports
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     start             request; sampled only in IDLE or DONE
//     M, S1, S0         mode (0 arith / 1 logic) and operation select
//     a_i, b_i          operands, captured on an accepted start
//     busy              high while bits are being processed
//     done              one-cycle pulse; x_o and the flags are valid
//     x_o               result
//     cout, ovf, zero   carry out of MSB, signed overflow, x_o == 0
module serial_alu_slice #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             M,
    input  logic             S1,
    input  logic             S0,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_o,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sr;
    logic             r_m;
    logic [1:0]       r_op;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_abit;
    logic             w_bbit;
    logic             w_y;
    logic             w_sum;
    logic             w_cout;
    logic             w_lbit;
    logic             w_bit;
    logic             w_cnext;
    logic             w_c0;
    logic             w_last;
    logic [WIDTH-1:0] w_res;

    assign w_abit = r_a[r_cnt];
    assign w_bbit = r_b[r_cnt];

    // Extender: the Y input of the adder for each arithmetic op.
    always_comb begin
        w_y = 1'b0;
        case (r_op)
            2'b00:   w_y = w_bbit;     // ADD
            2'b01:   w_y = ~w_bbit;    // SUB (two's complement, c0=1)
            2'b10:   w_y = 1'b0;       // INC (c0=1)
            default: w_y = 1'b1;       // DEC (add all-ones)
        endcase
    end

    // Logic-mode bit function.
    always_comb begin
        w_lbit = 1'b0;
        case (r_op)
            2'b00:   w_lbit = w_abit & w_bbit;
            2'b01:   w_lbit = w_abit | w_bbit;
            2'b10:   w_lbit = w_abit ^ w_bbit;
            default: w_lbit = ~w_abit;
        endcase
    end

    assign w_sum   = w_abit ^ w_y ^ r_carry;
    assign w_cout  = (w_abit & w_y) | (w_abit & r_carry) | (w_y & r_carry);
    assign w_bit   = r_m ? w_lbit : w_sum;
    assign w_cnext = r_m ? 1'b0 : w_cout;
    // Initial carry is 1 only for SUB (01) and INC (10) in arithmetic mode.
    assign w_c0    = ~M & (S1 ^ S0);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    // New bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign w_res   = {w_bit, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sr    <= '0;
            r_m     <= 1'b0;
            r_op    <= 2'b00;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            x_o     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_m     <= M;
                        r_op    <= {S1, S0};
                        r_carry <= w_c0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sr    <= w_res;
                    r_carry <= w_cnext;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        x_o     <= w_res;
                        cout    <= w_cnext;
                        // r_carry here is the carry into the MSB.
                        ovf     <= r_m ? 1'b0 : (r_carry ^ w_cout);
                        zero    <= (w_res == '0);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_slice.sv
module tb_serial_alu_slice;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         M = 1'b0, S1 = 1'b0, S0 = 1'b0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] x_o;

    int checks = 0;
    int errors = 0;

    serial_alu_slice #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .M(M), .S1(S1), .S0(S0),
        .a_i(a_i), .b_i(b_i), .busy(busy), .done(done), .x_o(x_o),
        .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {x, cout, ovf, zero}.
    function automatic logic [10:0] ref_op(input logic m, input logic [1:0] s,
                                           input logic [7:0] a, input logic [7:0] b);
        logic [8:0] f;
        logic [7:0] x;
        logic       c, v;
        f = '0; c = 1'b0; v = 1'b0; x = '0;
        if (m) begin
            case (s)
                2'd0: x = a & b;
                2'd1: x = a | b;
                2'd2: x = a ^ b;
                default: x = ~a;
            endcase
        end else begin
            case (s)
                2'd0: begin f = {1'b0, a} + {1'b0, b};         v = (a[7] == b[7]) && (f[7] != a[7]); end
                2'd1: begin f = {1'b0, a} + {1'b0, ~b} + 9'd1; v = (a[7] != b[7]) && (f[7] != a[7]); end
                2'd2: begin f = {1'b0, a} + 9'd1;              v = (a == 8'h7F); end
                default: begin f = {1'b0, a} + 9'h0FF;         v = (a == 8'h80); end
            endcase
            x = f[7:0];
            c = f[8];
        end
        return {x, c, v, (x == 8'h00)};
    endfunction

    // One operation: start for one cycle, scramble inputs during RUN, then check
    // busy length, the single done pulse and the results.
    task automatic run_op(input string tag, input logic m, input logic [1:0] s,
                          input logic [7:0] a, input logic [7:0] b);
        logic [10:0] e;
        int          bc;
        bit          seen;
        e = ref_op(m, s, a, b);
        @(negedge clk);
        M = m; {S1, S0} = s; a_i = a; b_i = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom); M = 1'($urandom); {S1, S0} = 2'($urandom);
        bc = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1;
            else begin
                if (busy) bc++;
                @(negedge clk);
            end
        end
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(bc), 32'(W));
        chk({tag, ".x"}, 32'(x_o), 32'(e[10:3]));
        chk({tag, ".cout"}, 32'(cout), 32'(e[2]));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e[1]));
        chk({tag, ".zero"}, 32'(zero), 32'(e[0]));
        @(negedge clk);
        chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
        chk({tag, ".x_held"}, 32'(x_o), 32'(e[10:3]));
    endtask

    initial begin
        int          nd, per;
        logic [10:0] e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.x", 32'(x_o), 32'd0);
        chk("rst.flags", 32'({cout, ovf, zero}), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op("T1.add", 1'b0, 2'd0, 8'h7F, 8'h01);
        run_op("T2.sub", 1'b0, 2'd1, 8'h05, 8'h05);
        run_op("T3.dec", 1'b0, 2'd3, 8'h00, 8'h00);
        run_op("T3.inc", 1'b0, 2'd2, 8'hFF, 8'h00);
        run_op("T4.and", 1'b1, 2'd0, 8'hF0, 8'h3C);
        run_op("T4.or",  1'b1, 2'd1, 8'hF0, 8'h3C);
        run_op("T4.xor", 1'b1, 2'd2, 8'hF0, 8'h3C);
        run_op("T4.not", 1'b1, 2'd3, 8'hF0, 8'h3C);
        run_op("sub.borrow", 1'b0, 2'd1, 8'h03, 8'h80);
        run_op("dec.ovf", 1'b0, 2'd3, 8'h80, 8'h00);

        // T5: a start pulse mid-RUN with different operands is ignored
        @(negedge clk);
        M = 1'b0; {S1, S0} = 2'd0; a_i = 8'h10; b_i = 8'h20; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        M = 1'b1; {S1, S0} = 2'd3; a_i = 8'hAA; b_i = 8'h55; start = 1'b1;
        @(negedge clk); start = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                nd++;
                chk("T5.x", 32'(x_o), 32'h30);
            end
            @(negedge clk);
        end
        chk("T5.done_count", 32'(nd), 32'd1);

        // Back-to-back: start held through DONE gives one op per W+1 cycles
        @(negedge clk);
        M = 1'b0; {S1, S0} = 2'd0; a_i = 8'h01; b_i = 8'h01; start = 1'b1;
        nd = 0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("b2b.first_done", 32'(done), 32'd1);
        per = 0;
        @(negedge clk); per++;
        for (int i = 0; i < 20 && !done; i++) begin @(negedge clk); per++; end
        start = 1'b0;
        chk("b2b.period", 32'(per), 32'(W + 1));
        chk("b2b.x", 32'(x_o), 32'h02);
        repeat (2) @(negedge clk);
        chk("b2b.idle", 32'(busy), 32'd0);

        // T6: reset at RUN bit 4 aborts at once with no done pulse
        @(negedge clk);
        M = 1'b0; {S1, S0} = 2'd0; a_i = 8'h11; b_i = 8'h22; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("T6.busy", 32'(busy), 32'd0);
        chk("T6.done", 32'(done), 32'd0);
        chk("T6.x", 32'(x_o), 32'd0);
        chk("T6.flags", 32'({cout, ovf, zero}), 32'd0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (i == 2) rst_n = 1'b1;
        end
        chk("T6.no_done", 32'(nd), 32'd0);
        chk("T6.idle", 32'(busy), 32'd0);
        run_op("T6.add", 1'b0, 2'd0, 8'h03, 8'h04);

        // Randomised operations against the reference
        for (int i = 0; i < 30; i++) begin
            run_op("rand", 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
        end

        // Model self-consistency at a boundary: INC of all-ones
        e = ref_op(1'b0, 2'd2, 8'hFF, 8'h00);
        run_op("inc.wrap", 1'b0, 2'd2, 8'hFF, 8'h5A);
        chk("inc.wrap.zero", 32'(zero), 32'(e[0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
